systolic_seq_ctrl: RTL and testbench

- Sequencer for a DIM x DIM systolic array of multiply-accumulate PEs.
- Each PE has a synchronous active-low clear, accumulates up*left every cycle, and forwards left->right and up->down.
- The block clears the array, reads K operand vectors from the A/B operand buffers, and skews them onto row/column edges with zero fill.
- It waits for the wavefront to drain, then pulses done and reports a sticky overflow flag built from the PE carry outputs.

---
 rtl/systolic_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: clears the PEs, streams K operand vectors
// with per-lane skew and zero fill, waits for the wavefront to drain, then flags done/overflow.
module systolic_seq_ctrl #(
    parameter int unsigned DIM        = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K_WIDTH    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [K_WIDTH-1:0]        k_len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      ovf_o,
    output logic                      rd_en_o,
    output logic [K_WIDTH-1:0]        rd_addr_o,
    input  logic [DIM*DATA_WIDTH-1:0] a_vec_i,
    input  logic [DIM*DATA_WIDTH-1:0] b_vec_i,
    output logic [DIM*DATA_WIDTH-1:0] left_o,
    output logic [DIM*DATA_WIDTH-1:0] up_o,
    output logic                      pe_rst_no,
    input  logic [DIM*DIM-1:0]        carry_i
);

    // 1 buffer cycle + 1 skew register + 2*(DIM-1) hops to the far corner
    localparam int unsigned DRAIN_CYCLES = 2 * DIM;
    localparam int unsigned DCNT_W       = $clog2(DRAIN_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StDone
    } state_e;

    state_e              r_state;
    logic [K_WIDTH-1:0]  r_k_len;
    logic [K_WIDTH-1:0]  r_rd_addr;
    logic [DCNT_W-1:0]   r_drain_cnt;
    logic                r_rd_en;
    logic                r_busy;
    logic                r_done;
    logic                r_ovf;
    logic                r_pe_rst_n;
    logic                r_vld;
    logic                w_carry_any;

    assign w_carry_any = |carry_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_k_len     <= '0;
            r_rd_addr   <= '0;
            r_drain_cnt <= '0;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_pe_rst_n  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state inside {StFeed, StDrain, StDone}) && w_carry_any) begin
                r_ovf <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    r_pe_rst_n <= 1'b1;
                    if (start_i) begin
                        r_k_len    <= k_len_i;
                        r_state    <= StClear;
                        r_busy     <= 1'b1;
                        r_pe_rst_n <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                StClear: begin
                    r_pe_rst_n <= 1'b1;
                    if (r_k_len != '0) begin
                        r_state   <= StFeed;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end else begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                StFeed: begin
                    // Compare against K-1 so K = 2^K_WIDTH-1 never needs a wider counter
                    if (r_rd_addr == r_k_len - K_WIDTH'(1)) begin
                        r_state     <= StDrain;
                        r_rd_en     <= 1'b0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + K_WIDTH'(1);
                    end
                end
                StDrain: begin
                    if (r_drain_cnt == DCNT_LAST) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DCNT_W'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Operand buffer answers one cycle after the read enable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= r_rd_en;
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_a_sr [gi+1];
        logic [DATA_WIDTH-1:0] r_b_sr [gi+1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 0; k <= gi; k++) begin
                    r_a_sr[k] <= '0;
                    r_b_sr[k] <= '0;
                end
            end else begin
                r_a_sr[0] <= r_vld ? a_vec_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                r_b_sr[0] <= r_vld ? b_vec_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= gi; k++) begin
                    r_a_sr[k] <= r_a_sr[k-1];
                    r_b_sr[k] <= r_b_sr[k-1];
                end
            end
        end

        assign left_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_a_sr[gi];
        assign up_o[gi*DATA_WIDTH +: DATA_WIDTH]   = r_b_sr[gi];
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign ovf_o     = r_ovf;
    assign rd_en_o   = r_rd_en;
    assign rd_addr_o = r_rd_addr;
    assign pe_rst_no = r_pe_rst_n;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl at DIM=2, 8-bit data: models the operand buffers and a 2x2 MAC
// array with 16-bit accumulators, and checks control timing, skewed edges and results.
module tb_systolic_seq_ctrl;

    localparam int unsigned DIM = 2;
    localparam int unsigned DW  = 8;
    localparam int unsigned KW  = 8;
    localparam int unsigned VW  = DIM * DW;

    logic           clk;
    logic           rst_i;
    logic           start_i;
    logic [KW-1:0]  k_len_i;
    logic           busy_o;
    logic           done_o;
    logic           ovf_o;
    logic           rd_en_o;
    logic [KW-1:0]  rd_addr_o;
    logic [VW-1:0]  a_vec_i;
    logic [VW-1:0]  b_vec_i;
    logic [VW-1:0]  left_o;
    logic [VW-1:0]  up_o;
    logic           pe_rst_no;
    logic [DIM*DIM-1:0] carry_i;

    systolic_seq_ctrl #(
        .DIM        (DIM),
        .DATA_WIDTH (DW),
        .K_WIDTH    (KW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .k_len_i   (k_len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ovf_o     (ovf_o),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .a_vec_i   (a_vec_i),
        .b_vec_i   (b_vec_i),
        .left_o    (left_o),
        .up_o      (up_o),
        .pe_rst_no (pe_rst_no),
        .carry_i   (carry_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [VW-1:0]   a_mem [256];
    logic [VW-1:0]   b_mem [256];
    logic [2*DW-1:0] pe_acc [DIM][DIM];
    logic [DW-1:0]   pe_h   [DIM][DIM];
    logic [DW-1:0]   pe_v   [DIM][DIM];
    logic            pe_c   [DIM][DIM];

    int n_checks;
    int n_fail;

    typedef struct {
        logic          busy;
        logic          done;
        logic          rden;
        logic [KW-1:0] addr;
        logic          pern;
        logic [VW-1:0] left;
        logic [VW-1:0] up;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: buffers answer the pre-edge read, PE mesh accumulates the pre-edge edges.
    task automatic tick();
        logic [VW-1:0]   l;
        logic [VW-1:0]   u;
        logic            prn;
        logic            ren;
        logic [KW-1:0]   addr;
        logic [DW-1:0]   in_l;
        logic [DW-1:0]   in_u;
        logic [2*DW-1:0] prod;
        logic [2*DW:0]   sum;
        logic [2*DW-1:0] nacc [DIM][DIM];
        logic [DW-1:0]   nh   [DIM][DIM];
        logic [DW-1:0]   nv   [DIM][DIM];
        logic            nc   [DIM][DIM];
        l    = left_o;
        u    = up_o;
        prn  = pe_rst_no;
        ren  = rd_en_o;
        addr = rd_addr_o;
        @(posedge clk);
        #1;
        if (ren) begin
            a_vec_i = a_mem[addr];
            b_vec_i = b_mem[addr];
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (j == 0) in_l = l[i*DW +: DW];
                else        in_l = pe_h[i][j-1];
                if (i == 0) in_u = u[j*DW +: DW];
                else        in_u = pe_v[i-1][j];
                prod = (2*DW)'(in_l) * (2*DW)'(in_u);
                sum  = {1'b0, pe_acc[i][j]} + {1'b0, prod};
                if (!prn) begin
                    nacc[i][j] = '0;
                    nh[i][j]   = '0;
                    nv[i][j]   = '0;
                    nc[i][j]   = 1'b0;
                end else begin
                    nacc[i][j] = sum[2*DW-1:0];
                    nh[i][j]   = in_l;
                    nv[i][j]   = in_u;
                    nc[i][j]   = pe_c[i][j] | sum[2*DW];
                end
            end
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                pe_acc[i][j] = nacc[i][j];
                pe_h[i][j]   = nh[i][j];
                pe_v[i][j]   = nv[i][j];
                pe_c[i][j]   = nc[i][j];
                carry_i[i*DIM+j] = nc[i][j];
            end
        end
    endtask

    task automatic start_job(input logic [KW-1:0] k);
        start_i = 1'b1;
        k_len_i = k;
        tick();
        start_i = 1'b0;
    endtask

    task automatic load_basic();
        a_mem[0] = {8'd3, 8'd1};
        a_mem[1] = {8'd4, 8'd2};
        b_mem[0] = {8'd6, 8'd5};
        b_mem[1] = {8'd8, 8'd7};
    endtask

    task automatic check_c(input string tag, input int c00, input int c01, input int c10,
                           input int c11);
        check($sformatf("%s_c00", tag), pe_acc[0][0], c00);
        check($sformatf("%s_c01", tag), pe_acc[0][1], c01);
        check($sformatf("%s_c10", tag), pe_acc[1][0], c10);
        check($sformatf("%s_c11", tag), pe_acc[1][1], c11);
    endtask

    // Assumes the address register starts at 0 (fresh out of reset)
    task automatic run_basic(input string tag);
        load_basic();
        start_job(2);
        for (int r = 0; r < 9; r++) begin
            if (r > 0) tick();
            check($sformatf("%s_ctl_s+%0d", tag, r + 1),
                  {busy_o, done_o, rd_en_o, rd_addr_o, pe_rst_no},
                  {tbl[r].busy, tbl[r].done, tbl[r].rden, tbl[r].addr, tbl[r].pern});
            check($sformatf("%s_edge_s+%0d", tag, r + 1), {left_o, up_o},
                  {tbl[r].left, tbl[r].up});
            if (r == 7) begin
                check_c(tag, 19, 22, 43, 50);
                check($sformatf("%s_ovf", tag), ovf_o, 0);
            end
        end
    endtask

    int done_cnt;
    int done_off;
    int rd_cnt;
    int last_addr;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b0;
        start_i  = 1'b0;
        k_len_i  = '0;
        a_vec_i  = '0;
        b_vec_i  = '0;
        carry_i  = '0;
        for (int k = 0; k < 256; k++) begin
            a_mem[k] = '0;
            b_mem[k] = '0;
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                pe_acc[i][j] = '0;
                pe_h[i][j]   = '0;
                pe_v[i][j]   = '0;
                pe_c[i][j]   = 1'b0;
            end
        end
        //             busy  done  rden  addr   pern  left      up
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 16'h0000, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 16'h0000, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0001, 16'h0005};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0302, 16'h0607};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0400, 16'h0800};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0000, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 16'h0000, 16'h0000};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 16'h0000, 16'h0000};

        #2 rst_i = 1'b1;
        tick();
        tick();
        check("reset_ctrl", {busy_o, done_o, ovf_o, rd_en_o, rd_addr_o, pe_rst_no}, 0);
        check("reset_edges", {left_o, up_o}, 0);
        rst_i = 1'b0;
        tick();
        check("idle_after_reset", {busy_o, pe_rst_no}, 2'b01);

        // Basic 2x2 product with edge skew
        run_basic("t1");
        tick();
        tick();

        // Overflow from all-255 operands, sticky into IDLE
        a_mem[0] = 16'hffff;
        a_mem[1] = 16'hffff;
        b_mem[0] = 16'hffff;
        b_mem[1] = 16'hffff;
        start_job(2);
        for (int r = 0; r < 7; r++) tick();
        check("t4_done_ovf", {done_o, ovf_o}, 2'b11);
        for (int r = 0; r < 5; r++) tick();
        check("t4_ovf_idle", {busy_o, ovf_o}, 2'b01);

        // K=0 with start held high: back-to-back jobs
        start_i = 1'b1;
        k_len_i = 8'd0;
        tick();
        check("t3_clear", {busy_o, done_o, pe_rst_no, ovf_o, rd_en_o}, 5'b10000);
        tick();
        check("t3_done", {busy_o, done_o, rd_en_o, ovf_o}, 4'b1100);
        check_c("t3", 0, 0, 0, 0);
        tick();
        check("t3_idle", {busy_o, done_o, rd_en_o}, 3'b000);
        tick();
        check("t3_restart", {busy_o, pe_rst_no, rd_en_o}, 3'b100);
        start_i = 1'b0;
        tick();
        check("t3_done2", {busy_o, done_o, rd_en_o}, 3'b110);
        tick();

        // Start pulses while busy are ignored
        start_job(3);
        done_cnt = 0;
        done_off = -1;
        rd_cnt   = 0;
        for (int off = 1; off <= 20; off++) begin
            if (off > 1) tick();
            if (done_o) begin
                done_cnt++;
                done_off = off;
            end
            if (rd_en_o) rd_cnt++;
            start_i = (off == 3) || (off == 7);
            k_len_i = (off == 3) ? 8'd7 : 8'd9;
        end
        start_i = 1'b0;
        check("t5_done_count", done_cnt, 1);
        check("t5_done_offset", done_off, 9);
        check("t5_read_count", rd_cnt, 3);

        // Largest K: address must reach 254 without wrapping
        start_job(255);
        done_off  = -1;
        rd_cnt    = 0;
        last_addr = -1;
        for (int off = 1; off <= 400; off++) begin
            if (off > 1) tick();
            if (rd_en_o) begin
                rd_cnt++;
                last_addr = int'(rd_addr_o);
            end
            if (done_o) begin
                done_off = off;
                break;
            end
        end
        check("kmax_done_offset", done_off, 261);
        check("kmax_read_count", rd_cnt, 255);
        check("kmax_last_addr", last_addr, 254);
        tick();
        tick();

        // Asynchronous reset in the middle of FEED
        load_basic();
        start_job(5);
        tick();
        tick();
        tick();
        check("t6_addr_before", rd_addr_o, 2);
        check("t6_left_before", left_o, 16'h0001);
        #2 rst_i = 1'b1;
        #1;
        check("t6_rst_ctrl", {busy_o, done_o, ovf_o, rd_en_o, rd_addr_o, pe_rst_no}, 0);
        check("t6_rst_edges", {left_o, up_o}, 0);
        tick();
        tick();
        rst_i = 1'b0;
        done_cnt = 0;
        for (int r = 0; r < 15; r++) begin
            tick();
            if (done_o) done_cnt++;
        end
        check("t6_no_done", done_cnt, 0);
        run_basic("t6_rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
